// File: rtl/aes_wb_pkg.sv
// ---------------------------------------------------------------------------
// aes_wb_pkg
// Shared definitions for the AES block writeback engine:
//   - FSM state encoding (IDLE / WRITE / DONE)
//   - words-per-block derivation (NW = BLK_W / WORD_W)
//   - word-index counter width (clog2(NW), at least one bit)
// ---------------------------------------------------------------------------
package aes_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wb_state_e;

    // Number of memory words that make up one cipher block.
    function automatic int wb_nw(input int blk_w, input int word_w);
        return blk_w / word_w;
    endfunction

    // Index counter width; a single-word block still needs one bit.
    function automatic int wb_idx_w(input int nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

endpackage

// File: rtl/aes_wb_fifo.sv
// ---------------------------------------------------------------------------
// aes_wb_fifo
// Synchronous FIFO holding pending {block, base} entries for the writeback
// engine. Flags are derived from a registered occupancy count.
// Ports:
//   clk, reset (async active-low), clr (sync flush)
//   push_i / wdata_i    : write side (ignored while full or during clr)
//   pop_i  / rdata_o    : read side, rdata_o shows the head entry
//   full_o / empty_o    : occupancy flags
// ---------------------------------------------------------------------------
module aes_wb_fifo #(
    parameter int WIDTH = 160,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push_s;
    logic             pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign push_s  = push_i & ~full_o & ~clr;
    assign pop_s   = pop_i & ~empty_o & ~clr;
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == {CNT_W{1'b0}});
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; clr flushes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else if (clr) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_s)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_s, pop_s})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/aes_blk_writeback.sv
// ---------------------------------------------------------------------------
// aes_blk_writeback
// Writes buffered AES cipher blocks to data memory as NW consecutive words.
// Ports:
//   clk, reset (async active-low), clr (sync abort)
//   in_valid/in_ready/in_data/in_base : block input handshake
//   mem_we/mem_ready/mem_addr/mem_wdata : memory write port
//   busy  : buffer non-empty or FSM active
//   done  : one-cycle pulse after the last word of a block is accepted
//   blk_cnt : completed blocks since reset/clr (wraps)
// Build option: define AES_WB_BSWAP_EN to byte-reverse each written word.
// ---------------------------------------------------------------------------
module aes_blk_writeback
    import aes_wb_pkg::*;
#(
    parameter int BLK_W     = 128,
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int STRIDE    = 4,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BLK_W-1:0]  in_data,
    input  logic [ADDR_W-1:0] in_base,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       blk_cnt
);

    localparam int NW      = wb_nw(BLK_W, WORD_W);
    localparam int IDX_W   = wb_idx_w(NW);
    localparam int ENTRY_W = BLK_W + ADDR_W;

    wb_state_e         state_q;
    logic [BLK_W-1:0]  shift_q;
    logic [IDX_W-1:0]  idx_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [WORD_W-1:0] mem_wdata_q;
    logic              done_q;
    logic [15:0]       blk_cnt_q;

    logic [ENTRY_W-1:0] fifo_rdata_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               fifo_pop_s;
    logic [BLK_W-1:0]   rd_data_s;
    logic [ADDR_W-1:0]  rd_base_s;

    // Word formatting applied on the way to mem_wdata.
    function automatic logic [WORD_W-1:0] word_fmt(input logic [WORD_W-1:0] w);
`ifdef AES_WB_BSWAP_EN
        logic [WORD_W-1:0] r;
        r = w;
        for (int b = 0; b < WORD_W / 8; b++) begin
            r[8*b +: 8] = w[WORD_W-8-8*b +: 8];
        end
        return r;
`else
        return w;
`endif
    endfunction

    aes_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .push_i  (in_valid),
        .pop_i   (fifo_pop_s),
        .wdata_i ({in_data, in_base}),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign rd_data_s  = fifo_rdata_s[ENTRY_W-1 -: BLK_W];
    assign rd_base_s  = fifo_rdata_s[ADDR_W-1:0];
    // A block is only taken from the buffer in IDLE, so a pop never overlaps a write.
    assign fifo_pop_s = (state_q == ST_IDLE) & ~fifo_empty_s & ~clr;

    assign in_ready  = ~fifo_full_s;
    assign busy      = ~fifo_empty_s | (state_q != ST_IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign blk_cnt   = blk_cnt_q;

    // Writeback FSM with registered memory-port and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= {BLK_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {WORD_W{1'b0}};
            done_q      <= 1'b0;
            blk_cnt_q   <= 16'd0;
        end else if (clr) begin
            state_q     <= ST_IDLE;
            shift_q     <= {BLK_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {WORD_W{1'b0}};
            done_q      <= 1'b0;
            blk_cnt_q   <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (!fifo_empty_s) begin
                        // Present word 0 now; remaining words wait in the shift register.
                        state_q     <= ST_WRITE;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= rd_base_s;
                        mem_wdata_q <= word_fmt(rd_data_s[BLK_W-1 -: WORD_W]);
                        shift_q     <= rd_data_s << WORD_W;
                        idx_q       <= {IDX_W{1'b0}};
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        if (idx_q == IDX_W'(NW - 1)) begin
                            state_q   <= ST_DONE;
                            mem_we_q  <= 1'b0;
                            done_q    <= 1'b1;
                            blk_cnt_q <= blk_cnt_q + 16'd1;
                        end else begin
                            idx_q       <= idx_q + IDX_W'(1);
                            mem_addr_q  <= mem_addr_q + ADDR_W'(STRIDE);
                            mem_wdata_q <= word_fmt(shift_q[BLK_W-1 -: WORD_W]);
                            shift_q     <= shift_q << WORD_W;
                        end
                    end else begin
                        state_q <= ST_WRITE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    mem_we_q <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_blk_writeback.sv
// ---------------------------------------------------------------------------
// tb_aes_blk_writeback
// Directed bench for aes_blk_writeback (default parameters). Memory writes
// and done pulses are logged by a monitor and compared against hand values.
// ---------------------------------------------------------------------------
module tb_aes_blk_writeback;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = 128'd0;
    logic [31:0]  in_base = 32'd0;
    logic         mem_we;
    logic         mem_ready = 1'b0;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         busy;
    logic         done;
    logic [15:0]  blk_cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];

    localparam logic [127:0] BLK1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    aes_blk_writeback #(
        .BLK_W(128), .WORD_W(32), .ADDR_W(32), .STRIDE(4), .BUF_DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_base(in_base),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    // Log accepted memory writes and done pulses.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && mem_we && mem_ready) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wc_q.push_back(cyc);
        end
        if (reset && done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_w(input logic [31:0] w);
`ifdef AES_WB_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] t3_word(input int k, input int j);
        return {16'hA5A5, 8'(k), 8'(j)};
    endfunction

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        done_cnt = 0;
    endtask

    // Offer a block starting at a negedge; returns at the negedge after the handshake.
    task automatic send_blk(input logic [127:0] d, input logic [31:0] b);
        int n;
        in_valid = 1'b1; in_data = d; in_base = b; n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_we", {63'd0, mem_we}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_blk_cnt", {48'd0, blk_cnt}, 64'd0);

        // Test 1: single block, memory always ready
        clear_log();
        mem_ready = 1'b1;
        send_blk(BLK1, 32'd500);
        in_valid = 1'b0;
        chk("t1_lat_we0", {63'd0, mem_we}, 64'd0);
        chk("t1_lat_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        chk("t1_lat_we1", {63'd0, mem_we}, 64'd1);
        chk("t1_first_addr", {32'd0, mem_addr}, 64'd500);
        wait_idle();
        chk("t1_nwr", 64'(wa_q.size()), 64'd4);
        if (wa_q.size() == 4) begin
            chk("t1_a0", {32'd0, wa_q[0]}, 64'd500);
            chk("t1_a1", {32'd0, wa_q[1]}, 64'd504);
            chk("t1_a2", {32'd0, wa_q[2]}, 64'd508);
            chk("t1_a3", {32'd0, wa_q[3]}, 64'd512);
            chk("t1_d0", {32'd0, wd_q[0]}, {32'd0, exp_w(32'h00112233)});
            chk("t1_d1", {32'd0, wd_q[1]}, {32'd0, exp_w(32'h44556677)});
            chk("t1_d2", {32'd0, wd_q[2]}, {32'd0, exp_w(32'h8899AABB)});
            chk("t1_d3", {32'd0, wd_q[3]}, {32'd0, exp_w(32'hCCDDEEFF)});
            chk("t1_consec", 64'(wc_q[3] - wc_q[0]), 64'd3);
`ifdef AES_WB_BSWAP_EN
            chk("t6_bswap", {32'd0, wd_q[0]}, 64'h33221100);
`endif
        end
        chk("t1_done", 64'(done_cnt), 64'd1);
        chk("t1_blk_cnt", {48'd0, blk_cnt}, 64'd1);

        // Test 2: memory stalls for 3 cycles on word 2
        clear_log();
        send_blk(BLK1, 32'd500);
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_we && mem_addr == 32'd508) break;
            @(negedge clk);
        end
        chk("t2_seen508", {32'd0, mem_addr}, 64'd508);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_hold_addr", {32'd0, mem_addr}, 64'd508);
            chk("t2_hold_data", {32'd0, mem_wdata}, {32'd0, exp_w(32'h8899AABB)});
            chk("t2_hold_we", {63'd0, mem_we}, 64'd1);
        end
        mem_ready = 1'b1;
        wait_idle();
        chk("t2_nwr", 64'(wa_q.size()), 64'd4);
        chk("t2_done", 64'(done_cnt), 64'd1);
        chk("t2_blk_cnt", {48'd0, blk_cnt}, 64'd2);

        // Test 3: three back-to-back blocks against a stalled memory
        clear_log();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send_blk({t3_word(k, 0), t3_word(k, 1), t3_word(k, 2), t3_word(k, 3)},
                     32'd1000 + 32'(k) * 32'h100);
        end
        in_valid = 1'b0;
        chk("t3_in_ready_low", {63'd0, in_ready}, 64'd0);
        repeat (5) @(negedge clk);
        chk("t3_no_writes", 64'(wa_q.size()), 64'd0);
        chk("t3_hold_addr", {32'd0, mem_addr}, 64'd1000);
        chk("t3_busy", {63'd0, busy}, 64'd1);
        mem_ready = 1'b1;
        wait_idle();
        chk("t3_nwr", 64'(wa_q.size()), 64'd12);
        if (wa_q.size() == 12) begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 4; j++) begin
                    chk("t3_addr", {32'd0, wa_q[4*k+j]}, 64'(1000 + 256*k + 4*j));
                    chk("t3_data", {32'd0, wd_q[4*k+j]}, {32'd0, exp_w(t3_word(k, j))});
                end
            end
        end
        chk("t3_done", 64'(done_cnt), 64'd3);
        chk("t3_blk_cnt", {48'd0, blk_cnt}, 64'd5);

        // Test 4: clr after word 1 with one block pending
        clear_log();
        mem_ready = 1'b1;
        send_blk(BLK1, 32'd2000);
        send_blk(BLK1, 32'd3000);
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wa_q.size() >= 2) break;
            @(negedge clk);
        end
        chk("t4_two_words", 64'(wa_q.size()), 64'd2);
        clr = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        chk("t4_we", {63'd0, mem_we}, 64'd0);
        chk("t4_busy", {63'd0, busy}, 64'd0);
        chk("t4_blk_cnt", {48'd0, blk_cnt}, 64'd0);
        chk("t4_in_ready", {63'd0, in_ready}, 64'd1);
        mem_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_no_more_wr", 64'(wa_q.size()), 64'd2);
        chk("t4_no_done", 64'(done_cnt), 64'd0);
        chk("t4_blk_cnt_after", {48'd0, blk_cnt}, 64'd0);

        // Test 5: address wrap
        clear_log();
        send_blk(BLK1, 32'hFFFFFFF8);
        in_valid = 1'b0;
        wait_idle();
        chk("t5_nwr", 64'(wa_q.size()), 64'd4);
        if (wa_q.size() == 4) begin
            chk("t5_a0", {32'd0, wa_q[0]}, 64'hFFFFFFF8);
            chk("t5_a1", {32'd0, wa_q[1]}, 64'hFFFFFFFC);
            chk("t5_a2", {32'd0, wa_q[2]}, 64'h00000000);
            chk("t5_a3", {32'd0, wa_q[3]}, 64'h00000004);
        end
        chk("t5_blk_cnt", {48'd0, blk_cnt}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
